// File: rtl/team_06_audio_pkg.sv
// Shared definitions for the team_06 audio record/playback controller.
//   ctrl_state_t        : SRAM handshake FSM states
//   BYTES_PER_WORD      : audio samples packed into one SRAM word
//   DEFAULT_DEPTH_WORDS : default number of SRAM words reserved for audio
//   SILENCE             : sample value returned when no data is buffered
//   lane_mask()         : byte-lane mask covering the lowest n lanes
package team_06_audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } ctrl_state_t;

  localparam int         BYTES_PER_WORD      = 4;
  localparam int         DEFAULT_DEPTH_WORDS = 8192;
  localparam logic [7:0] SILENCE             = 8'h00;

  // 1 -> 4'b0001, 2 -> 4'b0011, 3 -> 4'b0111
  function automatic logic [3:0] lane_mask(input logic [1:0] n);
    lane_mask = 4'((5'd1 << n) - 5'd1);
  endfunction

endpackage

// File: rtl/team_06_sample_packer.sv
// Packs 8-bit samples into 32-bit words (first sample in bits [7:0]) and
// hands completed words to the SRAM FSM through a single pending slot.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : start of a recording; discards any partially packed word
//   accept       : sample_in is accepted this cycle
//   flush        : end of recording; closes a partial word (1-3 bytes)
//   sample_in    : sample byte
//   word_addr    : word address to attach to the word closed this cycle
//   ack          : FSM has taken the pending word this cycle
//   pending      : a word is waiting to be written
//   pend_data/pend_bsel/pend_addr : the waiting word, its lanes and address
//   word_closed  : a word was closed this cycle (queued or dropped)
//   overrun      : sticky; a closed word was dropped because the slot was busy
module team_06_sample_packer
  import team_06_audio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic        flush,
  input  logic [7:0]  sample_in,
  input  logic [15:0] word_addr,
  input  logic        ack,
  output logic        pending,
  output logic [31:0] pend_data,
  output logic [3:0]  pend_bsel,
  output logic [15:0] pend_addr,
  output logic        word_closed,
  output logic        overrun
);

  logic [31:0] pack_reg;
  logic [1:0]  count_reg;
  logic        pending_reg;
  logic [31:0] pend_data_reg;
  logic [3:0]  pend_bsel_reg;
  logic [15:0] pend_addr_reg;
  logic        overrun_reg;

  logic [31:0] pack_base;
  logic [31:0] pack_fill;
  logic [1:0]  count_base;
  logic        close_full;
  logic        close_part;
  logic        close_any;
  logic [3:0]  close_bsel;

  // A sample arriving on the clear cycle becomes the first byte of a new word.
  assign count_base = clear ? 2'd0 : count_reg;
  assign pack_base  = clear ? 32'd0 : pack_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign pack_fill[gi*8 +: 8] = (accept && (count_base == 2'(gi))) ?
                                    sample_in : pack_base[gi*8 +: 8];
    end
  endgenerate

  assign close_full = accept && (count_base == 2'(BYTES_PER_WORD - 1));
  assign close_part = flush && (count_base != 2'd0);
  assign close_any  = close_full || close_part;
  assign close_bsel = close_full ? 4'b1111 : lane_mask(count_base);

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_reg      <= 32'd0;
      count_reg     <= 2'd0;
      pending_reg   <= 1'b0;
      pend_data_reg <= 32'd0;
      pend_bsel_reg <= 4'd0;
      pend_addr_reg <= 16'd0;
      overrun_reg   <= 1'b0;
    end else begin
      if (close_any) begin
        pack_reg  <= 32'd0;
        count_reg <= 2'd0;
      end else begin
        pack_reg  <= pack_fill;
        count_reg <= count_base + 2'(accept);
      end

      // The slot frees on ack, so a word closing on the ack cycle still fits.
      if (close_any && (!pending_reg || ack)) begin
        pending_reg   <= 1'b1;
        pend_data_reg <= pack_fill;
        pend_bsel_reg <= close_bsel;
        pend_addr_reg <= word_addr;
      end else if (ack) begin
        pending_reg <= 1'b0;
      end

      if (close_any && pending_reg && !ack) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign pending     = pending_reg;
  assign pend_data   = pend_data_reg;
  assign pend_bsel   = pend_bsel_reg;
  assign pend_addr   = pend_addr_reg;
  assign word_closed = close_any;
  assign overrun     = overrun_reg;

endmodule

// File: rtl/team_06_audio_mem_ctrl.sv
// Audio record/playback controller in front of the team_06 word SRAM.
// Record mode packs samples into words and writes them; playback mode
// prefetches one word at a time and returns one sample per request.
// Optional feature macro: AUDIO_LOOP_PLAYBACK_EN (playback wraps to the
// start of the recording instead of stopping with play_done).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   mode_rec, mode_play          : level mode selects (record wins)
//   sample_in, sample_valid      : record sample strobe
//   sample_req                   : playback request strobe
//   sample_out, sample_out_valid : playback answer, one cycle after request
//   rec_len                      : recorded length in bytes
//   full, overrun, underrun      : sticky status
//   play_done                    : playback delivered rec_len bytes
//   sram_*                       : SRAM word request/busy handshake
module team_06_audio_mem_ctrl
  import team_06_audio_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int BASE_ADDR   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_rec,
  input  logic        mode_play,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid,
  input  logic        sample_req,
  output logic [7:0]  sample_out,
  output logic        sample_out_valid,
  output logic [15:0] rec_len,
  output logic        full,
  output logic        overrun,
  output logic        underrun,
  output logic        play_done,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  output logic        sram_write_en,
  output logic        sram_read_en,
  output logic [3:0]  sram_byte_select,
  input  logic [31:0] sram_read_data,
  input  logic        sram_busy
);

  ctrl_state_t state_reg, state_next;

  logic        mode_rec_d_reg, mode_play_d_reg;
  logic [15:0] wr_ptr_reg, rec_len_reg, rd_ptr_reg, delivered_reg;
  logic        full_reg, underrun_reg, play_done_reg, rd_stale_reg;
  logic [31:0] buf_word_reg;
  logic        buf_valid_reg;
  logic [1:0]  byte_idx_reg;
  logic [7:0]  sample_out_reg;
  logic        sample_out_valid_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  bsel_reg;

  logic        rec_rise, rec_fall, play_active, play_rise;
  logic        accept, pend_ack, rd_issue, rd_done;
  logic        want_read, data_avail, last_byte;
  logic [15:0] words_rec;
  logic        pending, word_closed, packer_overrun;
  logic [31:0] pend_data;
  logic [3:0]  pend_bsel;
  logic [15:0] pend_addr;

  assign rec_rise    = mode_rec && !mode_rec_d_reg;
  assign rec_fall    = !mode_rec && mode_rec_d_reg;
  assign play_active = mode_play && !mode_rec;
  assign play_rise   = play_active && !mode_play_d_reg;

  // On the record start cycle full is about to clear, so do not block.
  assign accept = sample_valid && mode_rec && (!full_reg || rec_rise);

  assign words_rec  = 16'((17'(rec_len_reg) + 17'd3) >> 2);
  assign want_read  = play_active && !play_rise && !buf_valid_reg &&
                      !play_done_reg && (rd_ptr_reg < words_rec);
  assign data_avail = play_active && !play_rise && buf_valid_reg;
  assign last_byte  = (delivered_reg + 16'd1) == rec_len_reg;

  team_06_sample_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (rec_rise),
    .accept      (accept),
    .flush       (rec_fall),
    .sample_in   (sample_in),
    .word_addr   (wr_ptr_reg),
    .ack         (pend_ack),
    .pending     (pending),
    .pend_data   (pend_data),
    .pend_bsel   (pend_bsel),
    .pend_addr   (pend_addr),
    .word_closed (word_closed),
    .overrun     (packer_overrun)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pending writes outrank prefetch reads so recording never stalls on playback.
  always_comb begin
    state_next    = state_reg;
    pend_ack      = 1'b0;
    rd_issue      = 1'b0;
    rd_done       = 1'b0;
    sram_write_en = 1'b0;
    sram_read_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending) begin
          pend_ack   = 1'b1;
          state_next = WR_REQ;
        end else if (want_read) begin
          rd_issue   = 1'b1;
          state_next = RD_REQ;
        end
      end
      WR_REQ: begin
        sram_write_en = 1'b1;
        state_next    = WR_WAIT;
      end
      WR_WAIT: begin
        if (sram_busy) begin
          sram_write_en = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RD_REQ: begin
        sram_read_en = 1'b1;
        state_next   = RD_WAIT;
      end
      RD_WAIT: begin
        if (sram_busy) begin
          sram_read_en = 1'b1;
        end else begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_rec_d_reg       <= 1'b0;
      mode_play_d_reg      <= 1'b0;
      addr_reg             <= 32'd0;
      wdata_reg            <= 32'd0;
      bsel_reg             <= 4'd0;
      wr_ptr_reg           <= 16'd0;
      rec_len_reg          <= 16'd0;
      full_reg             <= 1'b0;
      rd_ptr_reg           <= 16'd0;
      delivered_reg        <= 16'd0;
      play_done_reg        <= 1'b0;
      underrun_reg         <= 1'b0;
      rd_stale_reg         <= 1'b0;
      buf_word_reg         <= 32'd0;
      buf_valid_reg        <= 1'b0;
      byte_idx_reg         <= 2'd0;
      sample_out_reg       <= 8'd0;
      sample_out_valid_reg <= 1'b0;
    end else begin
      mode_rec_d_reg  <= mode_rec;
      mode_play_d_reg <= mode_play;

      // Transfer registers are loaded once and held until the next request.
      if (pend_ack) begin
        addr_reg  <= 32'(BASE_ADDR) + {16'd0, pend_addr};
        wdata_reg <= pend_data;
        bsel_reg  <= pend_bsel;
      end else if (rd_issue) begin
        addr_reg <= 32'(BASE_ADDR) + {16'd0, rd_ptr_reg};
        bsel_reg <= 4'd0;
      end

      // Word slots are allocated when a word closes, so full tracks packed
      // words rather than completed SRAM writes.
      if (rec_rise) begin
        wr_ptr_reg <= 16'd0;
        full_reg   <= 1'b0;
      end else if (word_closed) begin
        wr_ptr_reg <= wr_ptr_reg + 16'd1;
        if (wr_ptr_reg == 16'(DEPTH_WORDS - 1)) begin
          full_reg <= 1'b1;
        end
      end
      rec_len_reg <= (rec_rise ? 16'd0 : rec_len_reg) + 16'(accept);

      sample_out_valid_reg <= sample_req;
      if (sample_req) begin
        sample_out_reg <= data_avail ? buf_word_reg[{byte_idx_reg, 3'b000} +: 8] : SILENCE;
        if (!data_avail) begin
          underrun_reg <= 1'b1;
        end
      end

      // A read still in flight across a playback restart returns stale data.
      if (rd_done) begin
        rd_stale_reg <= 1'b0;
      end else if (play_rise && (state_reg == RD_REQ || state_reg == RD_WAIT)) begin
        rd_stale_reg <= 1'b1;
      end

      if (play_rise) begin
        rd_ptr_reg    <= 16'd0;
        byte_idx_reg  <= 2'd0;
        delivered_reg <= 16'd0;
        play_done_reg <= 1'b0;
        buf_valid_reg <= 1'b0;
      end else begin
        if (rd_done && !rd_stale_reg) begin
          buf_word_reg  <= sram_read_data;
          buf_valid_reg <= 1'b1;
          rd_ptr_reg    <= rd_ptr_reg + 16'd1;
        end
        if (sample_req && data_avail) begin
          delivered_reg <= delivered_reg + 16'd1;
          byte_idx_reg  <= byte_idx_reg + 2'd1;
          // The last word of a recording may be partial; stop at rec_len.
          if (byte_idx_reg == 2'd3 || last_byte) begin
            buf_valid_reg <= 1'b0;
            byte_idx_reg  <= 2'd0;
          end
          if (last_byte) begin
`ifdef AUDIO_LOOP_PLAYBACK_EN
            rd_ptr_reg    <= 16'd0;
            delivered_reg <= 16'd0;
`else
            play_done_reg <= 1'b1;
`endif
          end
        end
      end
    end
  end

  assign sample_out       = sample_out_reg;
  assign sample_out_valid = sample_out_valid_reg;
  assign rec_len          = rec_len_reg;
  assign full             = full_reg;
  assign overrun          = packer_overrun;
  assign underrun         = underrun_reg;
  assign play_done        = play_done_reg;
  assign sram_address     = addr_reg;
  assign sram_write_data  = wdata_reg;
  assign sram_byte_select = bsel_reg;

endmodule

// File: tb/tb_team_06_audio_mem_ctrl.sv
module tb_team_06_audio_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode_rec, mode_play, sample_valid, sample_req;
  logic [7:0]  sample_in;

  logic [7:0]  sample_out;
  logic        sample_out_valid, full, overrun, underrun, play_done;
  logic [15:0] rec_len;
  logic [31:0] sram_address, sram_write_data, sram_read_data;
  logic        sram_write_en, sram_read_en, sram_busy;
  logic [3:0]  sram_byte_select;

  logic [7:0]  s_sample_out;
  logic        s_sample_out_valid, s_full, s_overrun, s_underrun, s_play_done;
  logic [15:0] s_rec_len;
  logic [31:0] s_sram_address, s_sram_write_data, s_sram_read_data;
  logic        s_sram_write_en, s_sram_read_en, s_sram_busy;
  logic [3:0]  s_sram_byte_select;

  team_06_audio_mem_ctrl u_dut (
    .clk(clk), .rst(rst), .mode_rec(mode_rec), .mode_play(mode_play),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_req(sample_req),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid), .rec_len(rec_len),
    .full(full), .overrun(overrun), .underrun(underrun), .play_done(play_done),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
    .sram_byte_select(sram_byte_select), .sram_read_data(sram_read_data),
    .sram_busy(sram_busy)
  );

  team_06_audio_mem_ctrl #(.DEPTH_WORDS(2)) u_small (
    .clk(clk), .rst(rst), .mode_rec(mode_rec), .mode_play(mode_play),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_req(sample_req),
    .sample_out(s_sample_out), .sample_out_valid(s_sample_out_valid), .rec_len(s_rec_len),
    .full(s_full), .overrun(s_overrun), .underrun(s_underrun), .play_done(s_play_done),
    .sram_address(s_sram_address), .sram_write_data(s_sram_write_data),
    .sram_write_en(s_sram_write_en), .sram_read_en(s_sram_read_en),
    .sram_byte_select(s_sram_byte_select), .sram_read_data(s_sram_read_data),
    .sram_busy(s_sram_busy)
  );

  // ---------------- SRAM model for the main instance ----------------
  logic [31:0] mem [0:255];
  logic [31:0] rd_addr_lat;
  int          busy_cnt, extra_busy, rd_count, we_cycles;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [3:0]  wlog_bsel[$];

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] bsel);
    merge_word = old_w;
    for (int l = 0; l < 4; l++)
      if (bsel[l]) merge_word[l*8 +: 8] = new_w[l*8 +: 8];
  endfunction

  assign sram_busy      = busy_cnt > 0;
  assign sram_read_data = mem[rd_addr_lat[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (sram_write_en || sram_read_en) begin
      busy_cnt <= 1 + extra_busy;
      if (sram_write_en) begin
        mem[sram_address[7:0]] <= merge_word(mem[sram_address[7:0]], sram_write_data, sram_byte_select);
        wlog_addr.push_back(sram_address);
        wlog_data.push_back(sram_write_data);
        wlog_bsel.push_back(sram_byte_select);
        $display("sram write addr=%0d data=%08h bsel=%b", sram_address, sram_write_data, sram_byte_select);
      end else begin
        rd_addr_lat <= sram_address;
        rd_count    <= rd_count + 1;
        $display("sram read  addr=%0d", sram_address);
      end
    end
  end

  always @(negedge clk) begin
    if (sram_write_en) we_cycles <= we_cycles + 1;
  end

  // ---------------- SRAM model for the DEPTH_WORDS=2 instance ----------------
  int s_busy_cnt, s_writes, s_high_writes;
  assign s_sram_busy      = s_busy_cnt > 0;
  assign s_sram_read_data = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      s_busy_cnt <= 0;
    end else if (s_busy_cnt > 0) begin
      s_busy_cnt <= s_busy_cnt - 1;
    end else if (s_sram_write_en || s_sram_read_en) begin
      s_busy_cnt <= 1;
      if (s_sram_write_en) begin
        s_writes <= s_writes + 1;
        if (s_sram_address >= 32'd2) s_high_writes <= s_high_writes + 1;
        $display("small sram write addr=%0d data=%08h bsel=%b", s_sram_address, s_sram_write_data, s_sram_byte_select);
      end
    end
  end

  // ---------------- checking and stimulus ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_bytes[$];
  logic       exp_ur;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode_rec = 1'b0; mode_play = 1'b0;
    sample_valid = 1'b0; sample_req = 1'b0; sample_in = 8'd0;
    exp_ur = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  // Records exp_bytes, then drops mode_rec and waits for the flush to drain.
  task automatic record_bytes(input int gap_min, input int gap_max, input int drain);
    int gap;
    mode_rec = 1'b1;
    tick(1);
    foreach (exp_bytes[i]) begin
      sample_in    = exp_bytes[i];
      sample_valid = 1'b1;
      tick(1);
      sample_valid = 1'b0;
      gap = $urandom_range(gap_max, gap_min);
      if (gap > 1) tick(gap - 1);
    end
    mode_rec = 1'b0;
    tick(drain);
  endtask

  // Expected writes: consecutive words from address 0, full lanes except a
  // partial last word; only enabled lanes are compared.
  task automatic check_writes(input int base);
    int          n, nw, idx;
    logic [31:0] exp_w, mask;
    logic [3:0]  exp_b;
    n  = exp_bytes.size();
    nw = (n + 3) / 4;
    check_val("write_count", 32'(wlog_addr.size() - base), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      exp_w = 32'd0; mask = 32'd0; exp_b = 4'd0;
      for (int l = 0; l < 4; l++) begin
        idx = 4 * k + l;
        if (idx < n) begin
          exp_w[l*8 +: 8] = exp_bytes[idx];
          mask[l*8 +: 8]  = 8'hff;
          exp_b[l]        = 1'b1;
        end
      end
      if (base + k < wlog_addr.size()) begin
        check_val("write_addr", wlog_addr[base + k], 32'(k));
        check_val("write_bsel", 32'(wlog_bsel[base + k]), 32'(exp_b));
        check_val("write_data", wlog_data[base + k] & mask, exp_w);
      end
    end
  endtask

  // Issues nreq spaced requests and compares each answer with the recording.
  task automatic play_check(input int nreq);
    int          n, rd_base;
    logic        silent, exp_done;
    logic [7:0]  eb;
    n       = exp_bytes.size();
    rd_base = rd_count;
    mode_play = 1'b1;
    tick(10);
    for (int k = 0; k < nreq; k++) begin
`ifdef AUDIO_LOOP_PLAYBACK_EN
      silent   = (n == 0);
      eb       = silent ? 8'h00 : exp_bytes[k % n];
      exp_done = 1'b0;
`else
      silent   = (k >= n);
      eb       = silent ? 8'h00 : exp_bytes[k];
      exp_done = (n > 0) && (k + 1 >= n);
`endif
      if (silent) exp_ur = 1'b1;
      sample_req = 1'b1;
      tick(1);
      sample_req = 1'b0;
      $display("play req %0d out=%02h valid=%b done=%b", k, sample_out, sample_out_valid, play_done);
      check_val("out_valid", 32'(sample_out_valid), 32'd1);
      check_val("sample_out", 32'(sample_out), 32'(eb));
      check_val("underrun", 32'(underrun), 32'(exp_ur));
      check_val("play_done", 32'(play_done), 32'(exp_done));
      tick(1);
      check_val("valid_pulse", 32'(sample_out_valid), 32'd0);
      tick($urandom_range(9, 6));
    end
`ifndef AUDIO_LOOP_PLAYBACK_EN
    check_val("read_count", 32'(rd_count - rd_base), 32'((n + 3) / 4));
`endif
    mode_play = 1'b0;
    tick(4);
  endtask

  initial begin
    int wb, web, sb, shb, n;
    extra_busy = 0;

    // reset state
    do_reset();
    check_val("rst_rec_len", 32'(rec_len), 32'd0);
    check_val("rst_flags", {28'd0, full, overrun, underrun, play_done}, 32'd0);
    check_val("rst_out_valid", 32'(sample_out_valid), 32'd0);
    check_val("rst_enables", {30'd0, sram_write_en, sram_read_en}, 32'd0);
    check_val("rst_address", sram_address, 32'd0);

    // one full word
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    wb = wlog_addr.size(); web = we_cycles;
    record_bytes(4, 4, 12);
    check_writes(wb);
    check_val("we_cycles", 32'(we_cycles - web), 32'd2);
    check_val("rec_len_4", 32'(rec_len), 32'd4);

    // partial word flushed on mode_rec fall, then played back
    do_reset();
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wb = wlog_addr.size();
    record_bytes(4, 4, 12);
    check_writes(wb);
    check_val("rec_len_6", 32'(rec_len), 32'd6);
    play_check(6);

    // long busy while samples stream in back-to-back
    do_reset();
    extra_busy = 5;
    exp_bytes = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'hb0, 8'hb1, 8'hb2, 8'hb3,
                  8'hc0, 8'hc1, 8'hc2, 8'hc3};
    wb = wlog_addr.size();
    record_bytes(1, 1, 40);
    extra_busy = 0;
    tick(4);
    check_val("overrun_set", 32'(overrun), 32'd1);
    check_val("ovr_rec_len", 32'(rec_len), 32'd12);
    if (wb < wlog_addr.size()) begin
      check_val("ovr_first_addr", wlog_addr[wb], 32'd0);
      check_val("ovr_first_data", wlog_data[wb], 32'ha3a2a1a0);
      check_val("ovr_first_bsel", 32'(wlog_bsel[wb]), 32'hf);
    end else begin
      check_val("ovr_first_present", 32'(wlog_addr.size() - wb), 32'd1);
    end

    // DEPTH_WORDS=2 instance fills up
    do_reset();
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h09, 8'h0a, 8'h0b, 8'h0c};
    sb = s_writes; shb = s_high_writes;
    record_bytes(4, 4, 12);
    check_val("small_full", 32'(s_full), 32'd1);
    check_val("small_rec_len", 32'(s_rec_len), 32'd8);
    check_val("small_writes", 32'(s_writes - sb), 32'd2);
    check_val("small_addr2", 32'(s_high_writes - shb), 32'd0);
    check_val("small_overrun", 32'(s_overrun), 32'd0);

    // 4-byte recording played with 9 requests (wraps when looping)
    do_reset();
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    record_bytes(4, 4, 12);
    play_check(9);

    // randomized recordings and playbacks
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(23, 1);
      exp_bytes = {};
      for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
      wb = wlog_addr.size();
      record_bytes(3, 6, 12);
      check_writes(wb);
      check_val("rnd_rec_len", 32'(rec_len), 32'(n));
      check_val("rnd_overrun", 32'(overrun), 32'd0);
      play_check(n + $urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
